// File: rtl/riscv_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// STATUS bit layout and the transmit FSM state encoding.
package riscv_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and an occupancy count.
// Pushes while full and pops while empty are ignored.
module riscv_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Storage is not reset; the pointers and count alone define the contents.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/riscv_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, TXDATA/STATUS/DIV registers,
// TX FIFO and the serialising FSM with a reloading baud down-counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line high, waiting for a byte in the FIFO
//   ST_START | start bit (low) for DIV+1 clocks
//   ST_DATA  | eight data bits, LSB first, DIV+1 clocks each
//   ST_STOP  | stop bit (high); chains straight into the next start bit
module riscv_uart_tx_mmio
    import riscv_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    output logic [31:0] drdata_o,
    input  logic [1:0]  dsize_i,
    input  logic        drd_i,
    input  logic        dwr_i,
    output logic        txd_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    logic [1:0]    reg_idx;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_div;
    logic          ovf_set;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;

    uart_state_e   state_q;
    logic [15:0]   baud_cnt_q;
    logic [15:0]   div_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          txd_q;
    logic          ovf_q;
    logic [31:0]   drdata_q;
    logic [31:0]   rd_data_next;
    logic [31:0]   status_word;
    logic          bit_done;
    logic          unused_bits;

    assign sel       = (daddr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_idx   = daddr_i[3:2];
    assign wr_txdata = dwr_i & sel & (reg_idx == REG_TXDATA);
    assign wr_status = dwr_i & sel & (reg_idx == REG_STATUS);
    assign wr_div    = dwr_i & sel & (reg_idx == REG_DIV);

    // Rejection looks at the registered full flag, so a same-cycle pop cannot rescue a push.
    assign fifo_push = wr_txdata & ~fifo_full;
    assign ovf_set   = wr_txdata & fifo_full;

    assign bit_done  = (baud_cnt_q == 16'd0);
    assign fifo_pop  = ~fifo_empty &
                       ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_done));

    riscv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fifo_push),
        .wdata_i (dwdata_i[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status_word                            = '0;
        status_word[STAT_FULL]                 = fifo_full;
        status_word[STAT_EMPTY]                = fifo_empty;
        status_word[STAT_BUSY]                 = (state_q != ST_IDLE);
        status_word[STAT_OVF]                  = ovf_q;
        status_word[STAT_COUNT_LSB +: CW]      = fifo_count;
    end

    always_comb begin
        rd_data_next = '0;
        if (drd_i & sel) begin
            case (reg_idx)
                REG_STATUS: rd_data_next = status_word;
                REG_DIV:    rd_data_next = {16'h0000, div_q};
                default:    rd_data_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            div_q    <= DIV_RESET;
            ovf_q    <= 1'b0;
            drdata_q <= '0;
        end else begin
            if (wr_div) begin
                div_q <= dwdata_i[15:0];
            end
            // A clear and a new overflow in the same cycle leave OVF set.
            ovf_q    <= ovf_set | (ovf_q & ~(wr_status & dwdata_i[STAT_OVF]));
            drdata_q <= rd_data_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q    <= fifo_rdata;
                        baud_cnt_q <= div_q;
                        txd_q      <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        baud_cnt_q <= div_q;
                        bit_idx_q  <= '0;
                        txd_q      <= shift_q[0];
                        state_q    <= ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        baud_cnt_q <= div_q;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (!fifo_empty) begin
                            shift_q    <= fifo_rdata;
                            baud_cnt_q <= div_q;
                            txd_q      <= 1'b0;
                            state_q    <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign txd_o    = txd_q;
    assign drdata_o = drdata_q;

    // Access size and byte offset do not matter: every register is a word.
    assign unused_bits = ^{dsize_i, daddr_i[1:0], dwdata_i[31:16]};

endmodule

// File: tb/tb_riscv_uart_tx_mmio.sv
// Self-checking bench for riscv_uart_tx_mmio: directed cases plus randomized
// traffic compared against a frame-timeline model of the transmitter.
module tb_riscv_uart_tx_mmio;

    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam int          DEPTH   = 8;
    localparam logic [31:0] A_TX    = BASE;
    localparam logic [31:0] A_ST    = BASE + 32'd4;
    localparam logic [31:0] A_DIV   = BASE + 32'd8;
    localparam logic [31:0] A_RSV   = BASE + 32'd12;
    localparam int          TRACE_N = 65536;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] daddr_i;
    logic [31:0] dwdata_i;
    logic [31:0] drdata_o;
    logic [1:0]  dsize_i;
    logic        drd_i;
    logic        dwr_i;
    logic        txd_o;

    riscv_uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (16'd15)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .daddr_i  (daddr_i),
        .dwdata_i (dwdata_i),
        .drdata_o (drdata_o),
        .dsize_i  (dsize_i),
        .drd_i    (drd_i),
        .dwr_i    (dwr_i),
        .txd_o    (txd_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic trace [TRACE_N];

    always @(negedge clk_i) begin
        if (cyc < TRACE_N) trace[cyc] <= txd_o;
    end

    // Model: each accepted byte becomes a frame on a timeline; everything
    // observable (line level, count, busy) is derived from that timeline.
    int         mw[$];
    int         ms[$];
    int         ml0[$];
    int         ml1[$];
    logic [7:0] mb[$];
    int         mdiv;
    bit         m_ovf;
    logic [7:0] dec_q[$];

    function automatic int frame_end(int k);
        return ms[k] + ml0[k] + 9 * ml1[k];
    endfunction

    function automatic int model_count(int t);
        int c = 0;
        for (int k = 0; k < mw.size(); k++) begin
            if (mw[k] < t) c++;
            if (ms[k] <= t) c--;
        end
        return c;
    endfunction

    function automatic bit model_busy(int t);
        for (int k = 0; k < ms.size(); k++)
            if (ms[k] <= t && t < frame_end(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_txd(int t);
        int off;
        int b;
        logic [7:0] v;
        for (int k = 0; k < ms.size(); k++) begin
            off = t - ms[k];
            if (off >= 0 && t < frame_end(k)) begin
                if (off < ml0[k]) return 1'b0;
                off = off - ml0[k];
                b = off / ml1[k];
                v = mb[k];
                if (b < 8) return v[b];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_status(int t);
        logic [31:0] s = '0;
        int c = model_count(t);
        s[0]    = (c == DEPTH);
        s[1]    = (c == 0);
        s[2]    = model_busy(t);
        s[3]    = m_ovf;
        s[11:8] = c[3:0];
        return s;
    endfunction

    function automatic void model_push(int w, logic [7:0] b);
        int s;
        if (model_count(w) >= DEPTH) begin
            m_ovf = 1'b1;
        end else begin
            s = w + 2;
            if (ms.size() > 0 && frame_end(ms.size() - 1) > s) s = frame_end(ms.size() - 1);
            mw.push_back(w);
            ms.push_back(s);
            ml0.push_back(mdiv + 1);
            ml1.push_back(mdiv + 1);
            mb.push_back(b);
        end
    endfunction

    function automatic void model_clear();
        mw.delete();
        ms.delete();
        ml0.delete();
        ml1.delete();
        mb.delete();
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        daddr_i  = a;
        dwdata_i = d;
        dsize_i  = 2'($urandom_range(0, 3));
        dwr_i    = 1'b1;
        tick();
        dwr_i    = 1'b0;
        daddr_i  = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        daddr_i = a;
        drd_i   = 1'b1;
        tick();
        drd_i   = 1'b0;
        daddr_i = '0;
        d       = drdata_o;
    endtask

    task automatic wait_idle();
        int target = cyc + 3;
        if (ms.size() > 0 && frame_end(ms.size() - 1) + 3 > target)
            target = frame_end(ms.size() - 1) + 3;
        while (cyc < target && cyc < TRACE_N - 16) tick();
    endtask

    task automatic check_wave(int from, int to);
        int nbad = 0;
        int first = -1;
        for (int t = from; t < to; t++) begin
            if (trace[t] !== model_txd(t)) begin
                nbad++;
                if (first < 0) first = t;
            end
        end
        check_eq($sformatf("txd_wave %0d..%0d first_bad=%0d", from, to, first), nbad, 0);
    endtask

    task automatic check_frames(int from, int to, int d);
        int i = from;
        int nfr = 0;
        logic [7:0] v;
        dec_q.delete();
        while (i + 10 * (d + 1) <= to) begin
            if (trace[i] === 1'b0) begin
                for (int k = 0; k < 8; k++) v[k] = trace[i + (k + 1) * (d + 1) + d / 2];
                dec_q.push_back(v);
                nfr++;
                i = i + 10 * (d + 1);
            end else begin
                i++;
            end
        end
        check_eq($sformatf("frame_count from %0d", from), nfr, mb.size());
        for (int k = 0; k < nfr && k < mb.size(); k++)
            check_eq($sformatf("frame_byte%0d from %0d", k, from), dec_q[k], mb[k]);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] e;
        logic [31:0] r32;
        logic [7:0]  b;
        int          w;
        int          t0;
        int          d;
        int          n;

        reset_i  = 1'b0;
        daddr_i  = '0;
        dwdata_i = '0;
        dsize_i  = '0;
        drd_i    = 1'b0;
        dwr_i    = 1'b0;
        mdiv     = 15;
        m_ovf    = 1'b0;

        repeat (3) tick();
        check_eq("reset_txd", txd_o, 1);
        check_eq("reset_drdata", drdata_o, 0);
        reset_i = 1'b1;
        tick();

        bus_rd(A_ST, r);
        check_eq("reset_status", r, 32'h0000_0002);
        bus_rd(A_DIV, r);
        check_eq("reset_div", r, 32'h0000_000F);
        tick();
        check_eq("drdata_no_read", drdata_o, 0);
        bus_rd(A_TX, r);
        check_eq("txdata_reads_zero", r, 0);
        bus_rd(A_RSV, r);
        check_eq("reserved_reads_zero", r, 0);
        bus_rd(BASE + 32'h14, r);
        check_eq("unselected_read_zero", r, 0);

        // Writes outside the window or to the reserved slot must not touch anything.
        model_clear();
        t0 = cyc;
        bus_wr(BASE + 32'h10, 32'h0000_00AA);
        bus_wr(BASE - 32'h10, 32'h0000_00AA);
        bus_wr(A_RSV, 32'hFFFF_FFFF);
        bus_rd(A_ST, r);
        check_eq("no_push_outside", r, 32'h0000_0002);
        bus_rd(A_DIV, r);
        check_eq("div_untouched", r, 32'h0000_000F);
        repeat (10) tick();
        check_wave(t0, cyc - 1);

        // DIV=3, single 0x55 frame
        bus_wr(A_DIV, 32'd3);
        mdiv = 3;
        model_clear();
        t0 = cyc;
        w  = cyc;
        bus_wr(A_TX, 32'h0000_0055);
        model_push(w, 8'h55);
        while (cyc < w + 41) tick();
        e = model_status(cyc);
        bus_rd(A_ST, r);
        check_eq("busy_last_stop_cycle", r[2], 1);
        check_eq("status_last_stop_cycle", r, e);
        e = model_status(cyc);
        bus_rd(A_ST, r);
        check_eq("busy_after_frame", r, 32'h0000_0002);
        check_eq("first_frame_latency", {trace[w + 1], trace[w + 2]}, 2'b10);
        wait_idle();
        check_wave(t0, cyc - 1);
        check_frames(t0, cyc - 1, 3);

        // DIV=0, three back-to-back bytes
        bus_wr(A_DIV, 32'd0);
        mdiv = 0;
        model_clear();
        t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            w = cyc;
            bus_wr(A_TX, 32'h41 + k);
            model_push(w, 8'(8'h41 + k));
        end
        wait_idle();
        check_wave(t0, cyc - 1);
        check_frames(t0, cyc - 1, 0);
        bus_rd(A_ST, r);
        check_eq("empty_after_burst", r, 32'h0000_0002);

        // DIV=15, overfill the FIFO with 10 consecutive writes
        bus_wr(A_DIV, 32'd15);
        mdiv = 15;
        model_clear();
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            w = cyc;
            b = 8'($urandom);
            bus_wr(A_TX, {24'h0, b});
            model_push(w, b);
        end
        e = model_status(cyc);
        bus_rd(A_ST, r);
        check_eq("fill_status_exact", r, 32'h0000_080D);
        check_eq("fill_status_model", r, e);
        bus_wr(A_ST, 32'h0000_0008);
        m_ovf = 1'b0;
        e = model_status(cyc);
        bus_rd(A_ST, r);
        check_eq("ovf_cleared", r, e);
        wait_idle();
        check_wave(t0, cyc - 1);
        check_frames(t0, cyc - 1, 15);

        // DIV changed from 3 to 7 during the start bit
        bus_wr(A_DIV, 32'd3);
        mdiv = 3;
        model_clear();
        t0 = cyc;
        w  = cyc;
        b  = 8'($urandom) | 8'h01;
        bus_wr(A_TX, {24'h0, b});
        model_push(w, b);
        tick();
        tick();
        bus_wr(A_DIV, 32'd7);
        mdiv   = 7;
        ml1[0] = 8;
        wait_idle();
        check_eq("div_change_start_len", {trace[w + 5], trace[w + 6], trace[w + 13], trace[w + 14]},
                 {1'b0, 1'b1, 1'b1, b[1]});
        check_eq("div_change_stop", {trace[w + 77], trace[w + 69]}, {1'b1, b[7]});
        check_wave(t0, cyc - 1);

        // Reset pulled low during the data bits
        bus_wr(A_DIV, 32'd3);
        mdiv = 3;
        model_clear();
        w = cyc;
        bus_wr(A_TX, 32'h0000_0000);
        model_push(w, 8'h00);
        bus_wr(A_TX, 32'h0000_005A);
        model_push(w + 1, 8'h5A);
        while (cyc < w + 10) tick();
        check_eq("pre_reset_txd", txd_o, model_txd(cyc));
        #2 reset_i = 1'b0;
        #1;
        check_eq("reset_async_txd", txd_o, 1);
        tick();
        tick();
        reset_i = 1'b1;
        model_clear();
        m_ovf = 1'b0;
        mdiv  = 15;
        t0    = cyc;
        bus_rd(A_ST, r);
        check_eq("post_reset_status", r, 32'h0000_0002);
        bus_rd(A_DIV, r);
        check_eq("post_reset_div", r, 32'h0000_000F);
        repeat (120) tick();
        check_wave(t0, cyc - 1);

        // Randomized traffic
        for (int it = 0; it < 8; it++) begin
            d   = $urandom_range(0, 4);
            r32 = $urandom;
            r32[15:0] = 16'(d);
            bus_wr(A_DIV, r32);
            mdiv = d;
            bus_rd(A_DIV, r);
            check_eq($sformatf("rand_div it%0d", it), r, d);
            model_clear();
            t0 = cyc;
            n  = $urandom_range(1, 12);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) tick();
                if ($urandom_range(0, 3) == 0) begin
                    e = model_status(cyc);
                    bus_rd(A_ST, r);
                    check_eq($sformatf("rand_status it%0d j%0d", it, j), r, e);
                end
                w   = cyc;
                r32 = $urandom;
                b   = r32[7:0];
                bus_wr(A_TX | 32'($urandom_range(0, 3)), r32);
                model_push(w, b);
            end
            e = model_status(cyc);
            bus_rd(A_ST, r);
            check_eq($sformatf("rand_status_end it%0d", it), r, e);
            if (m_ovf) begin
                bus_wr(A_ST, 32'h0000_0008 | ($urandom & 32'hFFFF_FFF0));
                m_ovf = 1'b0;
            end
            wait_idle();
            check_wave(t0, cyc - 1);
            check_frames(t0, cyc - 1, d);
            e = model_status(cyc);
            bus_rd(A_ST, r);
            check_eq($sformatf("rand_idle_status it%0d", it), r, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_uart_tx_mmio.md
# riscv_uart_tx_mmio

Memory-mapped UART transmitter on the core data bus, alongside `riscv_memory`. It decodes a 16-byte window at `BASE_ADDR`, buffers bytes written by firmware in a small FIFO, and serialises them as 8N1 frames on `txd_o`. This gives simulated firmware a console and lets benches check program output.

## Interface
- `BASE_ADDR`, default 32'h1000_0000: window base; must be 16-byte aligned.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two, at least 2.
- `DIV_RESET`, default 16'd15: reset value of DIV.
- `clk_i` input, 1 bit: single clock, rising edge.
- `reset_i` input, 1 bit: asynchronous, active-low reset.
- `daddr_i` input, 32 bits: data-bus address from the core.
- `dwdata_i` input, 32 bits: write data.
- `drdata_o` output, 32 bits: read data.
- `dsize_i` input, 2 bits: access size; ignored, since all registers are treated as words.
- `drd_i` input, 1 bit: read strobe.
- `dwr_i` input, 1 bit: write strobe.
- `txd_o` output, 1 bit: serial line, idle high.

## Operation
- Select: `sel = (daddr_i[31:4] == BASE_ADDR[31:4])`. The register index is `daddr_i[3:2]`; `daddr_i[1:0]` is ignored.
- Index 0, TXDATA (W):
  - `dwr_i & sel` pushes `dwdata_i[7:0]`.
  - If the FIFO is full, the byte is dropped and OVF is set.
  - A read returns 0.
- Index 1, STATUS (R/W1C):
  - [0] FULL.
  - [1] EMPTY.
  - [2] BUSY: FSM is not IDLE.
  - [3] OVF: sticky.
  - [8+:CW] FIFO count, where CW = clog2(FIFO_DEPTH)+1.
  - Other bits read 0.
  - Writing 1 to bit 3 clears OVF. If a clear and an overflow happen in the same cycle, OVF ends set.
- Index 2, DIV (R/W): 16-bit register holding bits [15:0]. One bit period is DIV+1 clocks, so DIV=0 gives 1 clock per bit.
- Index 3: reserved. Reads 0; writes are ignored.
- Unselected or non-read cycles: `drdata_o` = 0.
- FSM states are IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is not empty, pop into the shift register, go to START, and load the baud counter with DIV.
  - START: `txd_o`=0 for DIV+1 cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[idx]`, LSB first. After 8 bit periods, go to STOP.
  - STOP: `txd_o`=1 for one bit period. Then go to START if the FIFO is not empty (popping the next byte, no idle gap); otherwise go to IDLE.
- Baud counter: counts down and reloads from the current DIV at every bit boundary. A DIV write mid-bit takes effect from the next bit.
- FIFO:
  - A push that is not rejected and a pop in the same cycle leave the count unchanged.
  - Full rejection uses the registered full flag, so a push to a full FIFO is dropped even if a pop occurs that cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - `txd_o`=1, `drdata_o`=0.
  - FIFO empty, OVF=0, DIV=DIV_RESET, FSM=IDLE.
- Reset asserted mid-frame: `txd_o` goes high immediately (asynchronously) and the FIFO contents are discarded.

## Timing
- Reads: `drdata_o` is registered and valid in the cycle after `drd_i & sel`, matching `riscv_memory` read latency.
- Writes: take effect at the clock edge that samples `dwr_i`.
- First frame latency: TXDATA write in cycle N with the FIFO empty and FSM IDLE:
  - Count is 1 in N+1.
  - The FSM pops in N+1.
  - `txd_o` falls in N+2.
- Frame length: 10×(DIV+1) cycles. Back-to-back frames have no gap.
- STATUS: EMPTY and count reflect the pop one cycle after it occurs. BUSY is high from the START entry edge to the end of the last STOP cycle.

## Structure
- Package `riscv_uart_pkg` holds:
  - register index constants (TXDATA=0, STATUS=1, DIV=2),
  - STATUS bit positions,
  - the FSM state enum (2-bit).
- Sub-module `riscv_sync_fifo`: parameterised width and depth; push/pop, full/empty/count; asynchronous active-low reset.
- Top level contains the decoder, registers, baud counter and FSM.

## Test plan
- Reset held low: `txd_o`=1. After release, STATUS reads 0x0000_0002 (EMPTY) and DIV reads 0x0000_000F.
- DIV=3, write 0x55 to TXDATA:
  - `txd_o` is low 4 cycles starting 2 cycles after the write.
  - Then 1,0,1,0,1,0,1,0, each 4 cycles.
  - Then high 4 cycles.
  - BUSY drops after 40 cycles.
- DIV=0, write 0x41, 0x42, 0x43 back to back: three contiguous 10-cycle frames with no idle gap, and EMPTY reads set afterwards.
- With FIFO_DEPTH=8 and DIV=15, write 10 bytes in consecutive cycles:
  - The first byte is popped into the shift register by the FSM.
  - The FIFO then holds 8 entries and reports FULL.
  - The 10th byte is dropped and OVF=1.
  - Writing 0x8 to STATUS clears OVF.
  - Exactly 9 frames appear on `txd_o`.
- Write DIV=7 during a DIV=3 frame: the current bit stays 4 cycles; subsequent bits are 8 cycles.
- Pull `reset_i` low during the DATA bits of a frame: `txd_o`=1 immediately. After release, FSM is IDLE, the FIFO is empty, and no residual frame appears.
